// File: rtl/adsr_pitch_env_multi_if.sv
// rtl/adsr_pitch_env_multi_if.sv - gate/rate inputs and envelope outputs of adsr_pitch_env_multi
interface adsr_pitch_env_multi_if #(
    parameter int N_CH          = 4,
    parameter int VOLUME_BITS   = 8,
    parameter int FRAC_BITS     = 10,
    parameter int FREQ_RES_BITS = 8
);
    logic [N_CH-1:0]                    gate;
    logic [VOLUME_BITS+FRAC_BITS-1:0]   attack_inc;
    logic [VOLUME_BITS+FRAC_BITS-1:0]   decay_inc;
    logic [VOLUME_BITS+FRAC_BITS-1:0]   release_inc;
    logic [VOLUME_BITS-1:0]             sustain_lvl;
    logic [FREQ_RES_BITS-1:0]           pitch_depth;
    logic [N_CH*VOLUME_BITS-1:0]        volume_out;
    logic [N_CH*FREQ_RES_BITS-1:0]      freq_add_out;
    logic [N_CH-1:0]                    active;
    logic [N_CH-1:0]                    done;

    modport master (
        output gate, attack_inc, decay_inc, release_inc, sustain_lvl, pitch_depth,
        input  volume_out, freq_add_out, active, done
    );

    modport slave (
        input  gate, attack_inc, decay_inc, release_inc, sustain_lvl, pitch_depth,
        output volume_out, freq_add_out, active, done
    );
endinterface

// File: rtl/adsr_pitch_env_multi.sv
// rtl/adsr_pitch_env_multi.sv - multi-channel ADSR envelope with decaying pitch offset; ENV_EXP_RELEASE_EN selects exponential release
module adsr_pitch_env_multi #(
    parameter int N_CH          = 4,
    parameter int VOLUME_BITS   = 8,
    parameter int FRAC_BITS     = 10,
    parameter int MAX_VOL       = 64,
    parameter int FREQ_RES_BITS = 8,
    parameter int TICK_DIV      = 256,
    parameter int PITCH_DIV     = 64
) (
    input  logic                   mclk,
    input  logic                   rst,
    adsr_pitch_env_multi_if.slave  bus
);
    localparam int AW = VOLUME_BITS + FRAC_BITS;
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int PW = (PITCH_DIV > 1) ? $clog2(PITCH_DIV) : 1;
    localparam logic [AW:0] PEAK = (AW+1)'(MAX_VOL) << FRAC_BITS;

    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

    logic [TW-1:0]            pre_cnt;
    logic                     tick;
    state_t                   state    [N_CH];
    state_t                   nx_state [N_CH];
    logic [AW-1:0]            acc      [N_CH];
    logic [AW-1:0]            nx_acc   [N_CH];
    logic [FREQ_RES_BITS-1:0] freq     [N_CH];
    logic [FREQ_RES_BITS-1:0] nx_freq  [N_CH];
    logic [PW-1:0]            pcnt     [N_CH];
    logic [PW-1:0]            nx_pcnt  [N_CH];
    logic [VOLUME_BITS-1:0]   vol      [N_CH];
    logic [N_CH-1:0]          gate_prev;
    logic [N_CH-1:0]          rise;
    logic [N_CH-1:0]          fall;
    logic [N_CH-1:0]          nx_done;
    logic [N_CH-1:0]          active_q;
    logic [N_CH-1:0]          done_q;
    logic [AW:0]              s_lvl;
    logic [AW:0]              step;

    assign tick = (pre_cnt == TW'(TICK_DIV - 1));
    assign rise = bus.gate & ~gate_prev;
    assign fall = ~bus.gate & gate_prev;

    // Shared free-running tick prescaler
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) pre_cnt <= '0;
        else     pre_cnt <= tick ? '0 : pre_cnt + TW'(1);
    end

    // Next-state and level arithmetic per channel; one spare bit keeps saturation from wrapping
    always_comb begin
        s_lvl = (bus.sustain_lvl > VOLUME_BITS'(MAX_VOL)) ? PEAK
                                                          : ((AW+1)'(bus.sustain_lvl) << FRAC_BITS);
        step  = '0;
        for (int c = 0; c < N_CH; c++) begin
            nx_state[c] = state[c];
            nx_acc[c]   = acc[c];
            nx_freq[c]  = freq[c];
            nx_pcnt[c]  = pcnt[c];
            nx_done[c]  = 1'b0;
            if (rise[c]) begin
                // retrigger keeps acc so the attack resumes without a click
                nx_state[c] = ATTACK;
                nx_freq[c]  = bus.pitch_depth;
                nx_pcnt[c]  = '0;
            end else if (fall[c] && (state[c] == ATTACK || state[c] == DECAY || state[c] == SUSTAIN)) begin
                nx_state[c] = RELEASE;
            end else if (tick && state[c] != IDLE) begin
                if (pcnt[c] == PW'(PITCH_DIV - 1)) begin
                    nx_pcnt[c] = '0;
                    if (freq[c] != '0) nx_freq[c] = freq[c] - FREQ_RES_BITS'(1);
                end else begin
                    nx_pcnt[c] = pcnt[c] + PW'(1);
                end
                case (state[c])
                    ATTACK: begin
                        step = {1'b0, acc[c]} + {1'b0, bus.attack_inc};
                        if (step >= PEAK) begin
                            nx_acc[c]   = PEAK[AW-1:0];
                            nx_state[c] = DECAY;
                        end else begin
                            nx_acc[c] = step[AW-1:0];
                        end
                    end
                    DECAY: begin
                        step = s_lvl + {1'b0, bus.decay_inc};
                        if ({1'b0, acc[c]} <= step) begin
                            nx_acc[c]   = s_lvl[AW-1:0];
                            nx_state[c] = SUSTAIN;
                        end else begin
                            nx_acc[c] = acc[c] - bus.decay_inc;
                        end
                    end
                    RELEASE: begin
`ifdef ENV_EXP_RELEASE_EN
                        step = ({1'b0, acc[c]} >> bus.release_inc[3:0]) + (AW+1)'(1);
`else
                        step = {1'b0, bus.release_inc};
`endif
                        if ({1'b0, acc[c]} <= step) begin
                            nx_acc[c]   = '0;
                            nx_state[c] = IDLE;
                            nx_done[c]  = 1'b1;
                        end else begin
                            nx_acc[c] = acc[c] - step[AW-1:0];
                        end
                    end
                    default: ;
                endcase
            end
            if (nx_state[c] == IDLE) begin
                nx_acc[c]  = '0;
                nx_freq[c] = '0;
                nx_pcnt[c] = '0;
            end
        end
    end

    // Channel state, level, pitch and registered outputs
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            gate_prev <= '0;
            active_q  <= '0;
            done_q    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                state[c] <= IDLE;
                acc[c]   <= '0;
                freq[c]  <= '0;
                pcnt[c]  <= '0;
                vol[c]   <= '0;
            end
        end else begin
            gate_prev <= bus.gate;
            done_q    <= nx_done;
            for (int c = 0; c < N_CH; c++) begin
                state[c]    <= nx_state[c];
                acc[c]      <= nx_acc[c];
                freq[c]     <= nx_freq[c];
                pcnt[c]     <= nx_pcnt[c];
                vol[c]      <= acc[c][AW-1:FRAC_BITS];
                active_q[c] <= (nx_state[c] != IDLE);
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_out
        assign bus.volume_out[c*VOLUME_BITS +: VOLUME_BITS]       = vol[c];
        assign bus.freq_add_out[c*FREQ_RES_BITS +: FREQ_RES_BITS] = freq[c];
    end
    assign bus.active = active_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_adsr_pitch_env_multi.sv
// tb/tb_adsr_pitch_env_multi.sv - directed self-checking bench for adsr_pitch_env_multi
module tb_adsr_pitch_env_multi;
    logic       mclk = 1'b0;
    logic       rst;
    logic [1:0] tb_cnt;
    int         errors = 0;
    int         checks = 0;
    int         done0_cnt = 0;
    int         base;
    int         adsr_exp [8] = '{16, 32, 48, 64, 56, 48, 40, 32};
    int         rel_exp  [4] = '{24, 16, 8, 0};
    int         frq_exp  [8] = '{3, 2, 2, 1, 1, 0, 0, 0};

    always #5 mclk = ~mclk;

    adsr_pitch_env_multi_if #(.N_CH(4), .VOLUME_BITS(8), .FRAC_BITS(10), .FREQ_RES_BITS(8)) bus ();

    adsr_pitch_env_multi #(
        .N_CH(4), .VOLUME_BITS(8), .FRAC_BITS(10), .MAX_VOL(64),
        .FREQ_RES_BITS(8), .TICK_DIV(4), .PITCH_DIV(2)
    ) dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus)
    );

    // Reference prescaler phase: the DUT ticks on the edge leaving tb_cnt==3
    always @(posedge mclk or posedge rst) begin
        if (rst) tb_cnt <= 2'd0;
        else     tb_cnt <= tb_cnt + 2'd1;
    end

    always @(negedge mclk) begin
        if (bus.done[0] === 1'b1) done0_cnt <= done0_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] vol_of(input int c);
        return 32'(bus.volume_out[c*8 +: 8]);
    endfunction

    function automatic logic [31:0] frq_of(input int c);
        return 32'(bus.freq_add_out[c*8 +: 8]);
    endfunction

    task automatic set_gate(input int c, input logic v);
        while (tb_cnt != 2'd1) @(negedge mclk);
        bus.gate[c] = v;
        @(negedge mclk);
    endtask

    task automatic next_tick();
        while (tb_cnt != 2'd3) @(negedge mclk);
        @(negedge mclk);
        @(negedge mclk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.gate        = '0;
        bus.attack_inc  = 18'(16 << 10);
        bus.decay_inc   = 18'(8 << 10);
        bus.release_inc = 18'(8 << 10);
        bus.sustain_lvl = 8'd32;
        bus.pitch_depth = 8'd5;
        #12;
        check_eq("rst_volume", bus.volume_out, 0);
        check_eq("rst_active", 32'(bus.active), 0);
        check_eq("rst_done", 32'(bus.done), 0);
        #11 rst = 1'b0;
        @(negedge mclk);
        check_eq("idle_active", 32'(bus.active), 0);

        // reset asserted in the middle of an attack
        set_gate(0, 1'b1);
        check_eq("r_active", 32'(bus.active[0]), 1);
        check_eq("r_freq", frq_of(0), 5);
        next_tick();
        check_eq("r_vol_t1", vol_of(0), 16);
        next_tick();
        check_eq("r_vol_t2", vol_of(0), 32);
        @(negedge mclk);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_mid_volume", bus.volume_out, 0);
        check_eq("rst_mid_active", 32'(bus.active), 0);
        check_eq("rst_mid_freq", bus.freq_add_out, 0);
        bus.gate = '0;
        @(negedge mclk);
        rst = 1'b0;
        @(negedge mclk);
        check_eq("post_rst_active", 32'(bus.active), 0);
        check_eq("post_rst_volume", bus.volume_out, 0);

        // full attack/decay/sustain on ch0
        bus.pitch_depth = 8'd12;
        set_gate(0, 1'b1);
        check_eq("adsr_active", 32'(bus.active), 1);
        check_eq("adsr_freq_load", frq_of(0), 12);
        for (int i = 0; i < 8; i++) begin
            next_tick();
            check_eq($sformatf("adsr_vol_t%0d", i + 1), vol_of(0), 32'(adsr_exp[i]));
        end
        check_eq("adsr_freq_t8", frq_of(0), 8);
        next_tick();
        next_tick();
        check_eq("sustain_hold", vol_of(0), 32);
        check_eq("sustain_freq_t10", frq_of(0), 7);

        // ch1 starts while ch0 sustains
        set_gate(1, 1'b1);
        check_eq("ind_active", 32'(bus.active), 3);
        check_eq("ind_freq1", frq_of(1), 12);
        next_tick();
        check_eq("ind_vol1_t1", vol_of(1), 16);
        check_eq("ind_vol0_t1", vol_of(0), 32);
        next_tick();
        check_eq("ind_vol1_t2", vol_of(1), 32);
        check_eq("ind_vol0_t2", vol_of(0), 32);
        check_eq("ind_freq0", frq_of(0), 6);
        check_eq("ind_vol2", vol_of(2), 0);

        // release of ch0
        base = done0_cnt;
        set_gate(0, 1'b0);
        check_eq("rel_active", 32'(bus.active[0]), 1);
`ifdef ENV_EXP_RELEASE_EN
        begin
            logic [31:0] prev;
            logic [31:0] cur;
            int n;
            prev = 32;
            n = 0;
            do begin
                next_tick();
                cur = vol_of(0);
                check_eq("exp_rel_decreasing", 32'(cur < prev), 1);
                prev = cur;
                n++;
            end while (cur != 0 && n < 80);
            check_eq("exp_rel_zero", cur, 0);
        end
`else
        for (int i = 0; i < 4; i++) begin
            next_tick();
            check_eq($sformatf("rel_vol_t%0d", i + 1), vol_of(0), 32'(rel_exp[i]));
        end
`endif
        next_tick();
        check_eq("rel_done_once", 32'(done0_cnt - base), 1);
        check_eq("rel_idle_active", 32'(bus.active[0]), 0);
        check_eq("rel_idle_freq", frq_of(0), 0);
        check_eq("rel_idle_vol", vol_of(0), 0);

        // retrigger during release resumes from the current level
        bus.pitch_depth = 8'd5;
        set_gate(0, 1'b1);
        check_eq("rt_freq5", frq_of(0), 5);
        next_tick();
        next_tick();
        check_eq("rt_vol32", vol_of(0), 32);
        set_gate(0, 1'b0);
        next_tick();
`ifndef ENV_EXP_RELEASE_EN
        check_eq("rt_vol24", vol_of(0), 24);
        bus.pitch_depth = 8'd12;
        set_gate(0, 1'b1);
        check_eq("rt_freq_reload", frq_of(0), 12);
        check_eq("rt_active", 32'(bus.active[0]), 1);
        next_tick();
        check_eq("rt_vol40", vol_of(0), 40);
        next_tick();
        check_eq("rt_vol56", vol_of(0), 56);

        // pitch decay and sustain above MAX_VOL
        set_gate(0, 1'b0);
        next_tick();
        check_eq("p_vol48", vol_of(0), 48);
        bus.sustain_lvl = 8'd200;
        bus.pitch_depth = 8'd3;
        set_gate(0, 1'b1);
        check_eq("p_freq_load", frq_of(0), 3);
        for (int i = 0; i < 8; i++) begin
            next_tick();
            check_eq($sformatf("p_freq_t%0d", i + 1), frq_of(0), 32'(frq_exp[i]));
            check_eq($sformatf("p_vol_t%0d", i + 1), vol_of(0), 64);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
